// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush sequencer for the 5-stage pipeline; optional statistics counters under STALL_STATS_EN.
module pipeline_stall_ctrl #(
  parameter int MISS_TIMEOUT = 255,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_hit_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             refill_done_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);
  localparam int WW = $clog2(MISS_TIMEOUT + 1);
  localparam logic [WW-1:0] LAST = WW'(MISS_TIMEOUT - 1);
  typedef enum logic [1:0] {RUN, MISS, RELEASE, HALT} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic mem_req_q, mem_req_d, refill_done_q, refill_done_d, timeout_q, timeout_d;
  logic miss, lu, run, go;
  assign miss = dmem_req_i & ~dmem_hit_i;
  assign lu = idex_memread_i & (idex_rt_i != 5'd0) & ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
  assign run = state_q == RUN;
  assign go = run & ~miss & ~lu;
  assign pc_write_o = go;
  assign ifid_write_o = go;
  assign ifid_flush_o = go & branch_taken_i;
  assign idex_bubble_o = run & ~miss & lu;
  assign pipe_hold_o = ~run | miss;
  assign mem_req_o = mem_req_q;
  assign refill_done_o = refill_done_q;
  assign timeout_o = timeout_q;
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    mem_req_d = mem_req_q;
    refill_done_d = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      RUN: if (miss) begin
        state_d = MISS;
        wait_d = '0;
        mem_req_d = 1'b1;
      end
      MISS: begin
        wait_d = wait_q + 1'b1;
        if (mem_ack_i) begin
          state_d = RELEASE;
          mem_req_d = 1'b0;
          refill_done_d = 1'b1;
        end else if (wait_q == LAST) begin
          state_d = HALT;
          mem_req_d = 1'b0;
          timeout_d = 1'b1;
        end
      end
      RELEASE: state_d = RUN;
      default: ;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      wait_q <= '0;
      mem_req_q <= 1'b0;
      refill_done_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      mem_req_q <= mem_req_d;
      refill_done_q <= refill_done_d;
      timeout_q <= timeout_d;
    end
  end
`ifdef STALL_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, miss_cnt_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (idex_bubble_o && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (pipe_hold_o && state_q != HALT && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end
  assign stall_cnt_o = stall_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: scoreboard bench for pipeline_stall_ctrl against a cycle-level reference model.
module tb_pipeline_stall_ctrl;
  localparam int T = 4;
  localparam int CW = 4;
  localparam int SAT = 2**CW - 1;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic idex_memread_i = 1'b0, branch_taken_i = 1'b0, dmem_req_i = 1'b0, dmem_hit_i = 1'b1, mem_ack_i = 1'b0;
  logic [4:0] idex_rt_i = '0, ifid_rs_i = '0, ifid_rt_i = '0;
  logic mem_req_o, refill_done_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, timeout_o;
  logic [CW-1:0] stall_cnt_o, miss_cnt_o;
  always #5 clk_i = ~clk_i;
  pipeline_stall_ctrl #(.MISS_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
    .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i), .branch_taken_i(branch_taken_i),
    .dmem_req_i(dmem_req_i), .dmem_hit_i(dmem_hit_i), .mem_ack_i(mem_ack_i),
    .mem_req_o(mem_req_o), .refill_done_o(refill_done_o), .pc_write_o(pc_write_o),
    .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o),
    .pipe_hold_o(pipe_hold_o), .timeout_o(timeout_o), .stall_cnt_o(stall_cnt_o), .miss_cnt_o(miss_cnt_o)
  );
  typedef struct packed {
    logic pcw, ifw, fl, bub, hold, req, done, to;
    logic [CW-1:0] sc, mc;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0;
  string mode = "run";
  int waited = 0, sc_m = 0, mc_m = 0;
  task automatic step(input logic r, input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                      input logic [4:0] irt, input logic br, input logic rq, input logic ht, input logic ak);
    exp_t e;
    bit miss, lu;
    @(posedge clk_i);
    #1;
    rst_i = r; idex_memread_i = mr; idex_rt_i = rt; ifid_rs_i = rs; ifid_rt_i = irt;
    branch_taken_i = br; dmem_req_i = rq; dmem_hit_i = ht; mem_ack_i = ak;
    miss = rq && !ht;
    lu = mr && rt != 0 && (rt == rs || rt == irt);
    if (!r) begin
      mode = "run"; waited = 0; sc_m = 0; mc_m = 0;
    end
    e = '0;
    e.req = mode == "wait";
    e.done = mode == "rel";
    e.to = mode == "halt";
    if (mode == "run") begin
      if (miss) e.hold = 1'b1;
      else if (lu) e.bub = 1'b1;
      else begin
        e.pcw = 1'b1; e.ifw = 1'b1; e.fl = br;
      end
    end else e.hold = 1'b1;
`ifdef STALL_STATS_EN
    e.sc = CW'(sc_m);
    e.mc = CW'(mc_m);
`endif
    q.push_back(e);
    if (r) begin
      if (e.bub && sc_m < SAT) sc_m++;
      if (e.hold && mode != "halt" && mc_m < SAT) mc_m++;
      if (mode == "run") begin
        if (miss) begin mode = "wait"; waited = 0; end
      end else if (mode == "wait") begin
        waited++;
        if (ak) mode = "rel";
        else if (waited == T) mode = "halt";
      end else if (mode == "rel") mode = "run";
    end
  endtask
  task automatic idle(input logic ak);
    step(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, ak);
  endtask
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o, mem_req_o,
             refill_done_o, timeout_o, stall_cnt_o, miss_cnt_o};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL cycle %0d outputs got=%h expected=%h (pcw ifw fl bub hold req done to sc mc)", cyc, a, e);
        end
      end
    end
  end
  initial begin
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b1);
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b0); idle(1'b1); idle(1'b0); idle(1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b0);
    idle(1'b1);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1); idle(1'b0); idle(1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic r;
      r = !((mode == "halt" && $urandom_range(3) == 0) || $urandom_range(59) == 0);
      step(r, 1'($urandom_range(1)), 5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
           1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(3) != 0, $urandom_range(2) == 0);
    end
    idle(1'b0);
    @(negedge clk_i);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
